remote_cmd_pkt_tx: RTL and testbench
====================================

// Module: remote_cmd_pkt_tx
// PURPOSE
//  Parametrised remote command transmitter for the test/remote side of the serial link.
//  Accepts a command byte plus a DATA_BYTES-wide payload and sends cmd, then payload
//  MSB-byte-first, then an optional checksum byte, all over the 8-bit UART.
//  Adds a busy flag and optional response-timeout supervision.
//  Passes received response bytes through unchanged.
// PARAMETERS
//  DATA_BYTES  2        number of payload bytes after cmd (>=1)
//  CHKSUM_EN   0        1: append checksum byte after payload
//  TMO_CYCLES  1000000  clk cycles to wait for a response after cmd_sent; 0 = no supervision
// PORTS
//  clk           in   1              system clock
//  rst_n         in   1              asynchronous active-low reset
//  RX            in   1              serial in from DUT
//  TX            out  1              serial out to DUT, idles high
//  send_cmd      in   1              1-cycle request; accepted only when busy==0
//  cmd           in   8              command byte, sampled when send_cmd accepted
//  data          in   8*DATA_BYTES   payload, sampled when send_cmd accepted
//  busy          out  1              high from accept until return to IDLE
//  cmd_sent      out  1              1-cycle pulse on tx_done of final byte
//  resp_rdy      out  1              UART rx ready, passthrough
//  resp          out  8              UART rx byte, passthrough
//  clr_resp_rdy  in   1              clears resp_rdy (passthrough to UART)
//  resp_tmo      out  1              1-cycle pulse: no response within TMO_CYCLES
// BEHAVIOUR
//  Reset: state IDLE; busy, cmd_sent, resp_tmo, resp_rdy = 0; TX = 1; counters cleared.
//  States: IDLE -> SEND -> (WAIT_RESP if TMO_CYCLES!=0) -> IDLE.
//  IDLE: send_cmd=1 -> capture {cmd,data} into shift reg; byte index cleared; go SEND.
//    busy rises the cycle after the accept.
//  SEND: trmt pulses 1 cycle on state entry (one cycle after accept) with byte 0 (cmd),
//    then again in the same cycle as each tx_done for the next byte.
//    Byte order: cmd, data[8*DATA_BYTES-1 -: 8], ..., data[7:0], [chk].
//    Total bytes NB = 1 + DATA_BYTES + CHKSUM_EN.
//    The byte index counter counts to NB-1; its width is $clog2(NB+1).
//  Checksum: chk = ~(cmd + sum of data bytes) mod 256, accumulated from the captured
//    values, not the live inputs.
//  tx_done on byte NB-1: cmd_sent=1 for that cycle; go WAIT_RESP if TMO_CYCLES!=0,
//    otherwise go IDLE.
//  WAIT_RESP: timer counts from 0 each cycle.
//    resp_rdy=1 -> IDLE, no resp_tmo.
//    timer==TMO_CYCLES-1 with resp_rdy=0 -> resp_tmo=1 for 1 cycle, then IDLE.
//    resp_rdy and expiry in the same cycle -> the response wins; no resp_tmo.
//  send_cmd while busy=1: ignored, no capture; in-flight packet unaffected.
//  Latched bytes are stable through the packet; data/cmd may change after accept.
//  resp_rdy already high on entry to WAIT_RESP (stale) counts as a response.
//    The bench clears it before sending.
//  A response arriving during SEND is passed through but does not affect the FSM.
//  rst_n low mid-packet: immediate abort; UART resets, TX returns high, no cmd_sent.
// STRUCTURE
//  Shared pkg rc_pkg: typedef enum {IDLE,SEND,WAIT_RESP} rc_state_t.
//  Sub-module: the existing 8-bit UART transceiver (tx_data/trmt/tx_done,
//    rx_data/rx_rdy/clr_rx_rdy), instantiated once.
//  Everything else in this module: capture/shift reg, byte counter, checksum
//    accumulator, timer, FSM.
// TESTING
//  1 defaults, send_cmd cmd=8'h02 data=16'hABCD -> TX bytes 02,AB,CD in order;
//    cmd_sent pulses once; busy 1->0.
//  2 CHKSUM_EN=1, cmd=8'h10 data=16'h0102 -> bytes 10,01,02,EC; cmd_sent on the 4th tx_done.
//  3 DATA_BYTES=4, data=32'h11223344 -> 5 bytes, cmd first, then 11,22,33,44.
//  4 TMO_CYCLES=100, no RX reply -> resp_tmo pulse exactly 100 cycles after cmd_sent,
//    busy drops; reply 8'hA5 instead -> resp=A5, resp_rdy=1, no resp_tmo.
//  5 second send_cmd pulsed mid-packet with different cmd/data -> ignored; the original
//    bytes are sent unchanged.
//  6 rst_n asserted during byte 1 -> TX high, busy 0, no cmd_sent; a new send_cmd after
//    reset release completes normally.

Source files
------------

// File: rtl/remote_cmd_pkt_tx_pkg.sv
// Shared types and helpers for the remote command packet transmitter.
package rc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RESP
    } rc_state_t;

    localparam int UART_FRAME_BITS = 10;

    function automatic logic [7:0] chk_add(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc + b;
    endfunction

endpackage

// File: rtl/remote_cmd_pkt_tx_uart.sv
// 8-bit UART transceiver: 1 start, 8 data LSB-first, 1 stop.
// tx_done is a 1-cycle pulse after the stop bit; a trmt in that cycle starts the next frame.
module remote_cmd_pkt_tx_uart
    import rc_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic [7:0] i_tx_data,
    input  logic       i_trmt,
    output logic       o_tx_done,
    output logic [7:0] o_rx_data,
    output logic       o_rx_rdy,
    input  logic       i_clr_rx_rdy
);

    localparam logic [15:0] BAUD_M1   = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(UART_FRAME_BITS - 1);

    logic        r_tx_busy;
    logic [15:0] r_tx_baud;
    logic [3:0]  r_tx_bits;
    logic [9:0]  r_tx_shft;
    logic        r_tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_busy <= 1'b0;
            r_tx_baud <= '0;
            r_tx_bits <= '0;
            r_tx_shft <= '1;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (i_trmt) begin
                r_tx_shft <= {1'b1, i_tx_data, 1'b0};
                r_tx_busy <= 1'b1;
                r_tx_baud <= '0;
                r_tx_bits <= '0;
            end else if (r_tx_busy) begin
                if (r_tx_baud == BAUD_M1) begin
                    r_tx_baud <= '0;
                    r_tx_shft <= {1'b1, r_tx_shft[9:1]};
                    r_tx_bits <= r_tx_bits + 4'd1;
                    if (r_tx_bits == LAST_BIT) begin
                        r_tx_busy <= 1'b0;
                        r_tx_done <= 1'b1;
                    end
                end else begin
                    r_tx_baud <= r_tx_baud + 16'd1;
                end
            end
        end
    end

    assign o_tx      = r_tx_shft[0];
    assign o_tx_done = r_tx_done;

    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_busy;
    logic [15:0] r_rx_baud;
    logic [3:0]  r_rx_bits;
    logic [7:0]  r_rx_shft;
    logic        r_rx_rdy;

    // Samples land mid-bit: half a bit after the start edge, then every bit time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_busy <= 1'b0;
            r_rx_baud <= '0;
            r_rx_bits <= '0;
            r_rx_shft <= '0;
            r_rx_rdy  <= 1'b0;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            if (i_clr_rx_rdy) begin
                r_rx_rdy <= 1'b0;
            end
            if (!r_rx_busy) begin
                if (!r_rx_s2) begin
                    r_rx_busy <= 1'b1;
                    r_rx_baud <= BAUD_HALF;
                    r_rx_bits <= '0;
                    r_rx_rdy  <= 1'b0;
                end
            end else if (r_rx_baud == '0) begin
                r_rx_baud <= BAUD_M1;
                r_rx_bits <= r_rx_bits + 4'd1;
                if (r_rx_bits != '0 && r_rx_bits != LAST_BIT) begin
                    r_rx_shft <= {r_rx_s2, r_rx_shft[7:1]};
                end
                if (r_rx_bits == LAST_BIT) begin
                    r_rx_busy <= 1'b0;
                    r_rx_rdy  <= r_rx_s2;
                end
            end else begin
                r_rx_baud <= r_rx_baud - 16'd1;
            end
        end
    end

    assign o_rx_data = r_rx_shft;
    assign o_rx_rdy  = r_rx_rdy;

endmodule

// File: rtl/remote_cmd_pkt_tx.sv
// Remote command transmitter: sends cmd, payload MSB-byte-first and optional checksum
// over the UART, then optionally supervises the response with a timeout.
module remote_cmd_pkt_tx
    import rc_pkg::*;
#(
    parameter int DATA_BYTES = 2,
    parameter int CHKSUM_EN  = 0,
    parameter int TMO_CYCLES = 1000000,
    parameter int BAUD_DIV   = 434
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RX,
    output logic                    TX,
    input  logic                    send_cmd,
    input  logic [7:0]              cmd,
    input  logic [8*DATA_BYTES-1:0] data,
    output logic                    busy,
    output logic                    cmd_sent,
    output logic                    resp_rdy,
    output logic [7:0]              resp,
    input  logic                    clr_resp_rdy,
    output logic                    resp_tmo
);

    localparam int NB = 1 + DATA_BYTES + CHKSUM_EN;
    localparam int IW = $clog2(NB + 1);
    localparam int PW = 8 * DATA_BYTES;
    localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
    localparam logic [TW-1:0] TMO_LAST =
        TW'((TMO_CYCLES > 0) ? TMO_CYCLES - 1 : 0);
    localparam rc_state_t DONE_ST =
        (TMO_CYCLES != 0) ? WAIT_RESP : IDLE;

    rc_state_t       r_state;
    rc_state_t       w_nxt;
    logic [PW+7:0]   r_shft;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_nidx;
    logic            r_first;
    logic [7:0]      r_chk;
    logic [TW-1:0]   r_tmr;
    logic            w_accept;
    logic            w_trmt;
    logic            w_tx_done;
    logic            w_last_done;
    logic            w_expire;
    logic            w_is_chk;
    logic            w_rx_rdy;
    logic [7:0]      w_tx_byte;
    logic [7:0]      w_rx_data;

    assign w_accept    = (r_state == IDLE) && send_cmd;
    assign w_last_done = (r_state == SEND) && w_tx_done
                         && (r_idx == LAST_IDX);
    assign w_expire    = (r_state == WAIT_RESP) && (r_tmr == TMO_LAST);

    // The top of r_shft always holds the next unsent cmd/data byte.
    assign w_nidx    = r_first ? '0 : r_idx + IW'(1);
    assign w_is_chk  = (CHKSUM_EN != 0) && (w_nidx == LAST_IDX);
    assign w_tx_byte = w_is_chk ? ~r_chk : r_shft[PW+7 -: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (send_cmd) begin
                    w_nxt = SEND;
                end
            end
            SEND: begin
                if (w_last_done) begin
                    w_nxt = DONE_ST;
                end
            end
            WAIT_RESP: begin
                if (w_rx_rdy || w_expire) begin
                    w_nxt = IDLE;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        w_trmt   = 1'b0;
        cmd_sent = 1'b0;
        resp_tmo = 1'b0;
        unique case (r_state)
            SEND: begin
                busy     = 1'b1;
                w_trmt   = r_first || (w_tx_done && !w_last_done);
                cmd_sent = w_last_done;
            end
            WAIT_RESP: begin
                busy     = 1'b1;
                resp_tmo = w_expire && !w_rx_rdy;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shft  <= '0;
            r_idx   <= '0;
            r_first <= 1'b0;
            r_chk   <= '0;
            r_tmr   <= '0;
        end else begin
            if (w_accept) begin
                r_shft  <= {cmd, data};
                r_idx   <= '0;
                r_first <= 1'b1;
                r_chk   <= '0;
            end else if (w_trmt) begin
                r_shft  <= {r_shft[PW-1:0], 8'h00};
                r_chk   <= chk_add(r_chk, r_shft[PW+7 -: 8]);
                r_first <= 1'b0;
                r_idx   <= w_nidx;
            end
            if (r_state == SEND) begin
                r_tmr <= '0;
            end else if (r_state == WAIT_RESP) begin
                r_tmr <= r_tmr + TW'(1);
            end
        end
    end

    remote_cmd_pkt_tx_uart #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (RX),
        .o_tx        (TX),
        .i_tx_data   (w_tx_byte),
        .i_trmt      (w_trmt),
        .o_tx_done   (w_tx_done),
        .o_rx_data   (w_rx_data),
        .o_rx_rdy    (w_rx_rdy),
        .i_clr_rx_rdy(clr_resp_rdy)
    );

    assign resp_rdy = w_rx_rdy;
    assign resp     = w_rx_data;

endmodule

// File: tb/tb_remote_cmd_pkt_tx.sv
// Bench for remote_cmd_pkt_tx: three parameter sets, serial decode of TX against
// an expected byte queue, and per-cycle checks of busy/cmd_sent/resp_tmo.
module tb_remote_cmd_pkt_tx;

    localparam int BAUD  = 8;
    localparam int TMO_C = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        send_cmd = 1'b0;
    logic        clr_resp_rdy = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [31:0] data = 32'h0;
    int          sel = 0;

    logic       tx_a, busy_a, sent_a, rdy_a, tmo_a;
    logic       tx_b, busy_b, sent_b, rdy_b, tmo_b;
    logic       tx_c, busy_c, sent_c, rdy_c, tmo_c;
    logic [7:0] resp_a, resp_b, resp_c;

    logic       m_tx, m_busy, m_sent, m_rdy, m_tmo;
    logic [7:0] m_resp;

    int         n_chk = 0;
    int         n_fail = 0;
    int         n_sent = 0;
    int         n_tmo = 0;
    int         since = 0;
    bit         tmo_exp = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    remote_cmd_pkt_tx #(
        .DATA_BYTES(2), .CHKSUM_EN(0), .TMO_CYCLES(1000000), .BAUD_DIV(BAUD)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(tx_a),
        .send_cmd(send_cmd && sel == 0), .cmd(cmd), .data(data[15:0]),
        .busy(busy_a), .cmd_sent(sent_a), .resp_rdy(rdy_a), .resp(resp_a),
        .clr_resp_rdy(clr_resp_rdy), .resp_tmo(tmo_a)
    );

    remote_cmd_pkt_tx #(
        .DATA_BYTES(2), .CHKSUM_EN(1), .TMO_CYCLES(0), .BAUD_DIV(BAUD)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(tx_b),
        .send_cmd(send_cmd && sel == 1), .cmd(cmd), .data(data[15:0]),
        .busy(busy_b), .cmd_sent(sent_b), .resp_rdy(rdy_b), .resp(resp_b),
        .clr_resp_rdy(clr_resp_rdy), .resp_tmo(tmo_b)
    );

    remote_cmd_pkt_tx #(
        .DATA_BYTES(4), .CHKSUM_EN(0), .TMO_CYCLES(TMO_C), .BAUD_DIV(BAUD)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(tx_c),
        .send_cmd(send_cmd && sel == 2), .cmd(cmd), .data(data),
        .busy(busy_c), .cmd_sent(sent_c), .resp_rdy(rdy_c), .resp(resp_c),
        .clr_resp_rdy(clr_resp_rdy), .resp_tmo(tmo_c)
    );

    always_comb begin
        m_tx = tx_c; m_busy = busy_c; m_sent = sent_c;
        m_rdy = rdy_c; m_tmo = tmo_c; m_resp = resp_c;
        if (sel == 0) begin
            m_tx = tx_a; m_busy = busy_a; m_sent = sent_a;
            m_rdy = rdy_a; m_tmo = tmo_a; m_resp = resp_a;
        end else if (sel == 1) begin
            m_tx = tx_b; m_busy = busy_b; m_sent = sent_b;
            m_rdy = rdy_b; m_tmo = tmo_b; m_resp = resp_b;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // Packet model: cmd, payload bytes MSB first, then ~sum if enabled.
    function automatic void push_exp(input logic [7:0] c, input logic [31:0] d,
                                     input int nb, input bit ce);
        logic [7:0] s;
        s = c;
        exp_q.push_back(c);
        for (int i = nb - 1; i >= 0; i--) begin
            exp_q.push_back(d[8*i +: 8]);
            s = s + d[8*i +: 8];
        end
        if (ce) exp_q.push_back(~s);
    endfunction

    // Serial decoder on the selected TX line.
    initial begin : dec
        int cnt;
        bit act;
        logic [7:0] b;
        cnt = 0; act = 1'b0; b = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 1'b0;
            end else if (!act) begin
                if (m_tx == 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt == 4) chk("tx_start_bit", m_tx, 0);
                if (cnt >= 12 && cnt <= 68 && (cnt - 4) % 8 == 0)
                    b[(cnt - 12) / 8] = m_tx;
                if (cnt == 76) begin
                    act = 1'b0;
                    chk("tx_stop_bit", m_tx, 1);
                    got_q.push_back(b);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL tx_extra_byte: actual %0h required none", b);
                    end else begin
                        chk("tx_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : cmp
        forever begin
            @(negedge clk);
            since++;
            if (!m_busy) chk("tx_idle_high", m_tx, 1);
            if (m_sent) begin
                n_sent++;
                since = 0;
                chk("sent_after_all_bytes", exp_q.size(), 0);
                chk("sent_while_busy", m_busy, 1);
            end
            if (m_tmo) begin
                n_tmo++;
                chk("tmo_expected", tmo_exp, 1);
                chk("tmo_delay", since, TMO_C);
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic [31:0] d,
                        input int nb, input bit ce);
        push_exp(c, d, nb, ce);
        @(posedge clk); #1;
        cmd = c; data = d; send_cmd = 1'b1;
        @(negedge clk);
        chk("busy_before_accept", m_busy, 0);
        @(posedge clk); #1;
        send_cmd = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", m_busy, 1);
    endtask

    task automatic wait_sent(input string nm);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (m_sent) break;
        end
        chk(nm, m_sent, 1);
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 400; k++) begin
            if (!m_busy) break;
            @(negedge clk);
        end
        chk(nm, m_busy, 0);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BAUD) @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_rdy();
        @(posedge clk); #1;
        clr_resp_rdy = 1'b1;
        @(posedge clk); #1;
        clr_resp_rdy = 1'b0;
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0;
        int t0;
        repeat (3) @(negedge clk);
        chk("rst_tx_a", tx_a, 1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_sent_a", sent_a, 0);
        chk("rst_tmo_a", tmo_a, 0);
        chk("rst_rdy_a", rdy_a, 0);
        chk("rst_tx_b", tx_b, 1);
        chk("rst_busy_c", busy_c, 0);
        chk("rst_tx_c", tx_c, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        sel = 0; clr_rdy(); got_q.delete(); n0 = n_sent;
        send(8'h02, 32'h0000ABCD, 2, 1'b0);
        wait_sent("t1_cmd_sent");
        @(negedge clk);
        chk("t1_busy_wait_resp", m_busy, 1);
        rx_byte(8'h5A);
        wait_idle("t1_busy_drop");
        chk("t1_resp", m_resp, 8'h5A);
        chk("t1_resp_rdy", m_rdy, 1);
        chk("t1_sent_once", n_sent - n0, 1);
        chk("t1_nbytes", got_q.size(), 3);
        chk("t1_b0", got_q[0], 8'h02);
        chk("t1_b1", got_q[1], 8'hAB);
        chk("t1_b2", got_q[2], 8'hCD);

        sel = 1; clr_rdy(); got_q.delete();
        send(8'h10, 32'h00000102, 2, 1'b1);
        wait_sent("t2_cmd_sent");
        @(negedge clk);
        chk("t2_busy_drop", m_busy, 0);
        chk("t2_nbytes", got_q.size(), 4);
        chk("t2_b0", got_q[0], 8'h10);
        chk("t2_chk", got_q[3], 8'hEC);

        sel = 2; clr_rdy(); got_q.delete(); n0 = n_tmo;
        tmo_exp = 1'b1;
        send(8'h33, 32'h11223344, 4, 1'b0);
        wait_sent("t3_cmd_sent");
        t0 = 0;
        while (!m_tmo && t0 < 150) begin
            @(negedge clk);
            t0++;
        end
        chk("t4_tmo_pulse", m_tmo, 1);
        @(negedge clk);
        chk("t4_tmo_one_cycle", m_tmo, 0);
        chk("t4_busy_drop", m_busy, 0);
        tmo_exp = 1'b0;
        chk("t4_tmo_count", n_tmo - n0, 1);
        chk("t3_nbytes", got_q.size(), 5);
        chk("t3_b0", got_q[0], 8'h33);
        chk("t3_b1", got_q[1], 8'h11);
        chk("t3_b4", got_q[4], 8'h44);

        clr_rdy(); n0 = n_tmo;
        send(8'h44, 32'hDEADBEEF, 4, 1'b0);
        wait_sent("t4b_cmd_sent");
        rx_byte(8'hA5);
        wait_idle("t4b_busy_drop");
        chk("t4b_resp", m_resp, 8'hA5);
        chk("t4b_resp_rdy", m_rdy, 1);
        repeat (120) @(negedge clk);
        chk("t4b_no_tmo", n_tmo - n0, 0);

        sel = 0; clr_rdy(); got_q.delete(); n0 = n_sent;
        send(8'h55, 32'h00001234, 2, 1'b0);
        cmd = 8'hEE; data = 32'h00009999;
        repeat (100) @(posedge clk);
        #1;
        send_cmd = 1'b1; cmd = 8'hC3; data = 32'h00005AA5;
        @(posedge clk); #1;
        send_cmd = 1'b0;
        @(negedge clk);
        chk("t5_busy_held", m_busy, 1);
        wait_sent("t5_cmd_sent");
        rx_byte(8'h11);
        wait_idle("t5_busy_drop");
        chk("t5_sent_once", n_sent - n0, 1);
        chk("t5_nbytes", got_q.size(), 3);
        chk("t5_b0", got_q[0], 8'h55);
        chk("t5_b1", got_q[1], 8'h12);
        chk("t5_b2", got_q[2], 8'h34);

        clr_rdy(); got_q.delete(); n0 = n_sent;
        send(8'h66, 32'h00007788, 2, 1'b0);
        repeat (120) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t6_tx_high", m_tx, 1);
        chk("t6_busy_low", m_busy, 0);
        chk("t6_sent_low", m_sent, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_cmd_sent", n_sent - n0, 0);
        chk("t6_partial_bytes", got_q.size(), 1);
        chk("t6_b0", got_q[0], 8'h66);
        send(8'h21, 32'h00004321, 2, 1'b0);
        wait_sent("t6_resend_sent");
        rx_byte(8'h3C);
        wait_idle("t6_busy_drop");
        chk("t6_resend_once", n_sent - n0, 1);
        chk("t6_resend_b1", got_q[1], 8'h21);
        chk("t6_resend_b3", got_q[3], 8'h21);
        chk("t6_resp", m_resp, 8'h3C);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
